// File: rtl/df_axil_arbiter_pkg.sv
// Shared types for the AXI-Lite arbiter: FSM state encoding and response codes.
// Pure declarations; no latency or backpressure of its own.
package df_axil_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RRESP = 3'd4
  } arb_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/df_axil_arbiter_if.sv
// N_LANE parallel AXI-Lite ports as packed per-lane vectors (lane 0 only when N_LANE=1).
// Wires only; handshakes follow plain AXI-Lite valid/ready rules.
interface df_axil_arbiter_if #(
  parameter int N_LANE     = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [N_LANE-1:0]                     awvalid;
  logic [N_LANE-1:0]                     awready;
  logic [N_LANE-1:0][ADDR_WIDTH-1:0]     awaddr;
  logic [N_LANE-1:0]                     wvalid;
  logic [N_LANE-1:0]                     wready;
  logic [N_LANE-1:0][DATA_WIDTH-1:0]     wdata;
  logic [N_LANE-1:0][DATA_WIDTH/8-1:0]   wstrb;
  logic [N_LANE-1:0]                     bvalid;
  logic [N_LANE-1:0]                     bready;
  logic [N_LANE-1:0][1:0]                bresp;
  logic [N_LANE-1:0]                     arvalid;
  logic [N_LANE-1:0]                     arready;
  logic [N_LANE-1:0][ADDR_WIDTH-1:0]     araddr;
  logic [N_LANE-1:0]                     rvalid;
  logic [N_LANE-1:0]                     rready;
  logic [N_LANE-1:0][DATA_WIDTH-1:0]     rdata;
  logic [N_LANE-1:0][1:0]                rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/df_axil_arbiter_rr_pick.sv
// Rotate-priority picker: first set req bit at or after ptr_i, wrapping past N_REQ-1.
// Purely combinational, zero latency; no handshake.
module df_rr_pick #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic                     valid_o,
  output logic [$clog2(N_REQ)-1:0] idx_o
);
  localparam int IDX_W = $clog2(N_REQ);

  int j;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr_i) + k) % N_REQ;
      if (!valid_o && req_i[IDX_W'(j)]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/df_axil_arbiter.sv
// Round-robin N_REQ:1 AXI-Lite arbiter, one transaction in flight, grant held through the response.
// 1-cycle arbitration latency, responses pass through combinationally; ungranted requesters see ready=0.
module df_axil_arbiter
  import df_axil_arbiter_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  df_axil_arbiter_if.slave         req_if,
  df_axil_arbiter_if.master        mst_if,
  output logic [$clog2(N_REQ)-1:0] grant_o,
  output logic                     busy_o
);
  localparam int IDX_W = $clog2(N_REQ);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;

  logic [N_REQ-1:0] req_wr, req_rd, req;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic             aw_fire, w_fire;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // A write needs both AW and W present so the slave never sees a dangling address.
  assign req_wr = req_if.awvalid & req_if.wvalid;
  assign req_rd = req_if.arvalid;
  assign req    = req_wr | req_rd;

  df_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  assign mst_if.awaddr = req_if.awaddr[gnt_q];
  assign mst_if.wdata  = req_if.wdata[gnt_q];
  assign mst_if.wstrb  = req_if.wstrb[gnt_q];
  assign mst_if.araddr = req_if.araddr[gnt_q];
  assign req_if.rdata  = {N_REQ{mst_if.rdata[0]}};

  assign grant_o = gnt_q;
  assign busy_o  = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      rr_ptr_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_ptr_q  <= rr_ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    rr_ptr_d       = rr_ptr_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    aw_fire        = 1'b0;
    w_fire         = 1'b0;
    mst_if.awvalid = '0;
    mst_if.wvalid  = '0;
    mst_if.bready  = '0;
    mst_if.arvalid = '0;
    mst_if.rready  = '0;
    req_if.awready = '0;
    req_if.wready  = '0;
    req_if.bvalid  = '0;
    req_if.bresp   = {N_REQ{AXI_RESP_OKAY}};
    req_if.arready = '0;
    req_if.rvalid  = '0;
    req_if.rresp   = {N_REQ{AXI_RESP_OKAY}};

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_idx;
          state_d = req_wr[pick_idx] ? WADDR : RADDR;
        end
      end
      WADDR: begin
        mst_if.awvalid[0]     = req_if.awvalid[gnt_q] & ~aw_done_q;
        mst_if.wvalid[0]      = req_if.wvalid[gnt_q] & ~w_done_q;
        req_if.awready[gnt_q] = mst_if.awready[0] & ~aw_done_q;
        req_if.wready[gnt_q]  = mst_if.wready[0] & ~w_done_q;
        aw_fire = req_if.awvalid[gnt_q] & ~aw_done_q & mst_if.awready[0];
        w_fire  = req_if.wvalid[gnt_q] & ~w_done_q & mst_if.wready[0];
        if ((aw_done_q | aw_fire) && (w_done_q | w_fire)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WRESP;
        end else begin
          aw_done_d = aw_done_q | aw_fire;
          w_done_d  = w_done_q | w_fire;
        end
      end
      WRESP: begin
        req_if.bvalid[gnt_q] = mst_if.bvalid[0];
        req_if.bresp[gnt_q]  = mst_if.bresp[0];
        mst_if.bready[0]     = req_if.bready[gnt_q];
        if (mst_if.bvalid[0] && req_if.bready[gnt_q]) begin
          rr_ptr_d = next_idx(gnt_q);
          state_d  = IDLE;
        end
      end
      RADDR: begin
        mst_if.arvalid[0]     = req_if.arvalid[gnt_q];
        req_if.arready[gnt_q] = mst_if.arready[0];
        if (req_if.arvalid[gnt_q] && mst_if.arready[0]) begin
          state_d = RRESP;
        end
      end
      RRESP: begin
        req_if.rvalid[gnt_q] = mst_if.rvalid[0];
        req_if.rresp[gnt_q]  = mst_if.rresp[0];
        mst_if.rready[0]     = req_if.rready[gnt_q];
        if (mst_if.rvalid[0] && req_if.rready[gnt_q]) begin
          rr_ptr_d = next_idx(gnt_q);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_df_axil_arbiter.sv
// Directed bench for df_axil_arbiter with two requesters and a hand-driven slave.
// Inputs change 5 time units after the rising edge; outputs are checked 1 unit after each drive.
module tb_df_axil_arbiter;

  logic       clk;
  logic       rst_n;
  logic [0:0] grant;
  logic       busy;
  int         n_assert;
  int         n_fail;

  df_axil_arbiter_if #(.N_LANE(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) req_if ();
  df_axil_arbiter_if #(.N_LANE(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) mst_if ();

  df_axil_arbiter #(.N_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_if  (req_if),
    .mst_if  (mst_if),
    .grant_o (grant),
    .busy_o  (busy)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #5;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req_if.awvalid = '0; req_if.awaddr = '0; req_if.wvalid = '0; req_if.wdata = '0;
    req_if.wstrb   = '0; req_if.bready = '0; req_if.arvalid = '0; req_if.araddr = '0;
    req_if.rready  = '0;
    mst_if.awready = '0; mst_if.wready = '0; mst_if.bvalid = '0; mst_if.bresp = '0;
    mst_if.arready = '0; mst_if.rvalid = '0; mst_if.rdata  = '0; mst_if.rresp = '0;

    // Reset state
    tick(); tick();
    chk("rst_mst_awvalid", mst_if.awvalid, 0);
    chk("rst_mst_wvalid",  mst_if.wvalid,  0);
    chk("rst_mst_arvalid", mst_if.arvalid, 0);
    chk("rst_mst_bready",  mst_if.bready,  0);
    chk("rst_mst_rready",  mst_if.rready,  0);
    chk("rst_req_awready", req_if.awready, 0);
    chk("rst_busy",        busy,           0);
    chk("rst_grant",       grant,          0);
    rst_n = 1'b1;
    tick();

    // Single write from requester 0
    req_if.awvalid[0] = 1'b1; req_if.awaddr[0] = 32'h10;
    req_if.wvalid[0]  = 1'b1; req_if.wdata[0]  = 32'hDEADBEEF; req_if.wstrb[0] = 4'hF;
    mst_if.awready = 1'b1; mst_if.wready = 1'b1;
    #1;
    chk("wr_latency_awvalid", mst_if.awvalid, 0);
    chk("wr_latency_busy",    busy,           0);
    tick();
    chk("wr_mst_awvalid", mst_if.awvalid,   1);
    chk("wr_mst_awaddr",  mst_if.awaddr,    32'h10);
    chk("wr_mst_wvalid",  mst_if.wvalid,    1);
    chk("wr_mst_wdata",   mst_if.wdata,     32'hDEADBEEF);
    chk("wr_mst_wstrb",   mst_if.wstrb,     4'hF);
    chk("wr_req_awready", req_if.awready,   2'b01);
    chk("wr_busy",        busy,             1);
    chk("wr_grant",       grant,            0);
    tick();
    req_if.awvalid[0] = 1'b0; req_if.wvalid[0] = 1'b0;
    mst_if.bvalid = 1'b1; mst_if.bresp = 2'b00; req_if.bready[0] = 1'b1;
    #1;
    chk("wr_req_bvalid",  req_if.bvalid,    2'b01);
    chk("wr_req_bresp",   req_if.bresp[0],  0);
    chk("wr_mst_bready",  mst_if.bready,    1);
    chk("wr_mst_awvalid_done", mst_if.awvalid, 0);
    tick();
    mst_if.bvalid = 1'b0; req_if.bready = '0;
    #1;
    chk("wr_busy_after_b", busy, 0);

    // Contention: both read after a fresh reset, expect 0,1,0
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    req_if.arvalid = 2'b11; req_if.araddr[0] = 32'h100; req_if.araddr[1] = 32'h200;
    mst_if.arready = 1'b1;
    #1;
    chk("rd_latency_arvalid", mst_if.arvalid, 0);
    tick();
    chk("rd1_grant",       grant,          0);
    chk("rd1_mst_arvalid", mst_if.arvalid, 1);
    chk("rd1_mst_araddr",  mst_if.araddr,  32'h100);
    chk("rd1_req_arready", req_if.arready, 2'b01);
    tick();
    req_if.arvalid[0] = 1'b0;
    mst_if.rvalid = 1'b1; mst_if.rdata = 32'hA0; req_if.rready = 2'b01;
    #1;
    chk("rd1_req_rvalid",     req_if.rvalid,   2'b01);
    chk("rd1_req_rdata",      req_if.rdata[0], 32'hA0);
    chk("rd1_ignore_req1",    mst_if.arvalid,  0);
    chk("rd1_req1_noready",   req_if.arready,  2'b00);
    tick();
    mst_if.rvalid = 1'b0; req_if.rready = '0; req_if.arvalid[0] = 1'b1;
    #1;
    chk("rd1_idle", busy, 0);
    tick();
    chk("rd2_grant",      grant,         1);
    chk("rd2_mst_araddr", mst_if.araddr, 32'h200);
    tick();
    req_if.arvalid[1] = 1'b0;
    mst_if.rvalid = 1'b1; mst_if.rdata = 32'hB1; req_if.rready = 2'b10;
    #1;
    chk("rd2_req_rvalid", req_if.rvalid, 2'b10);
    tick();
    mst_if.rvalid = 1'b0; req_if.rready = '0;
    tick();
    chk("rd3_grant", grant, 0);
    tick();
    req_if.arvalid[0] = 1'b0;
    mst_if.rvalid = 1'b1; req_if.rready = 2'b01;
    tick();
    mst_if.rvalid = 1'b0; req_if.rready = '0; mst_if.arready = 1'b0;

    // Split AW/W: W accepted first, AW held off for three cycles
    req_if.awvalid[1] = 1'b1; req_if.awaddr[1] = 32'h40;
    req_if.wvalid[1]  = 1'b1; req_if.wdata[1]  = 32'h55AA; req_if.wstrb[1] = 4'h3;
    mst_if.awready = 1'b0; mst_if.wready = 1'b1;
    tick();
    chk("split_grant",       grant,          1);
    chk("split_mst_awvalid", mst_if.awvalid, 1);
    chk("split_mst_wvalid",  mst_if.wvalid,  1);
    chk("split_mst_wdata",   mst_if.wdata,   32'h55AA);
    chk("split_mst_wstrb",   mst_if.wstrb,   4'h3);
    chk("split_req_wready",  req_if.wready,  2'b10);
    chk("split_req_awready", req_if.awready, 2'b00);
    tick();
    req_if.wvalid[1] = 1'b0;
    #1;
    chk("split_no_dup_w_1", mst_if.wvalid,  0);
    chk("split_aw_pending", mst_if.awvalid, 1);
    chk("split_wready_off", req_if.wready,  2'b00);
    tick();
    chk("split_no_dup_w_2", mst_if.wvalid, 0);
    tick();
    mst_if.awready = 1'b1;
    #1;
    chk("split_req_awready_late", req_if.awready, 2'b10);
    chk("split_mst_awaddr",       mst_if.awaddr,  32'h40);
    chk("split_no_dup_w_3",       mst_if.wvalid,  0);
    tick();
    req_if.awvalid[1] = 1'b0;
    mst_if.bvalid = 1'b1; mst_if.bresp = 2'b10; req_if.bready[1] = 1'b1;
    #1;
    chk("split_wresp_awvalid", mst_if.awvalid,   0);
    chk("split_req_bvalid",    req_if.bvalid,    2'b10);
    chk("split_req_bresp",     req_if.bresp[1],  2'b10);
    chk("split_mst_bready",    mst_if.bready,    1);
    tick();
    mst_if.bvalid = 1'b0; mst_if.bresp = 2'b00; req_if.bready = '0;
    #1;
    chk("split_idle", busy, 0);

    // Requester 1 write+read together; requester 0 read arrives during the write
    req_if.awvalid[1] = 1'b1; req_if.awaddr[1] = 32'h80;
    req_if.wvalid[1]  = 1'b1; req_if.wdata[1]  = 32'h11223344; req_if.wstrb[1] = 4'hF;
    req_if.arvalid[1] = 1'b1; req_if.araddr[1] = 32'h84;
    mst_if.awready = 1'b1; mst_if.wready = 1'b1; mst_if.arready = 1'b1;
    tick();
    chk("wrd_grant_wr",    grant,          1);
    chk("wrd_mst_awvalid", mst_if.awvalid, 1);
    chk("wrd_mst_arvalid", mst_if.arvalid, 0);
    chk("wrd_req_arready", req_if.arready, 2'b00);
    req_if.arvalid[0] = 1'b1; req_if.araddr[0] = 32'h300;
    tick();
    req_if.awvalid[1] = 1'b0; req_if.wvalid[1] = 1'b0;
    mst_if.bvalid = 1'b1; req_if.bready[1] = 1'b1;
    #1;
    chk("wrd_req_bvalid", req_if.bvalid, 2'b10);
    tick();
    mst_if.bvalid = 1'b0; req_if.bready = '0;
    #1;
    chk("wrd_idle", busy, 0);
    tick();
    chk("wrd_grant_rd0",  grant,         0);
    chk("wrd_mst_araddr", mst_if.araddr, 32'h300);
    tick();
    req_if.arvalid[0] = 1'b0;

    // Read backpressure: requester 0 holds rready low for four cycles
    mst_if.rvalid = 1'b1; mst_if.rdata = 32'h12345678; mst_if.rresp = 2'b00;
    req_if.rready = 2'b00;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_req_rvalid",  req_if.rvalid,   2'b01);
      chk("bp_req_rdata",   req_if.rdata[0], 32'h12345678);
      chk("bp_mst_rready",  mst_if.rready,   0);
      chk("bp_grant_held",  grant,           0);
      chk("bp_busy",        busy,            1);
      chk("bp_no_arvalid",  mst_if.arvalid,  0);
      tick();
    end
    req_if.rready = 2'b01;
    #1;
    chk("bp_mst_rready_rel", mst_if.rready, 1);
    tick();
    mst_if.rvalid = 1'b0; req_if.rready = '0;
    tick();
    chk("wrd_grant_rd1",    grant,         1);
    chk("wrd_mst_araddr_1", mst_if.araddr, 32'h84);
    tick();
    req_if.arvalid[1] = 1'b0;
    mst_if.rvalid = 1'b1; mst_if.rdata = 32'hCAFE; req_if.rready = 2'b10;
    #1;
    chk("wrd_req_rvalid_1", req_if.rvalid,   2'b10);
    chk("wrd_req_rdata_1",  req_if.rdata[1], 32'hCAFE);
    tick();
    mst_if.rvalid = 1'b0; req_if.rready = '0;
    #1;
    chk("wrd_final_idle", busy, 0);

    // Asynchronous reset in the middle of a write address phase
    mst_if.awready = 1'b0; mst_if.wready = 1'b0;
    req_if.awvalid[1] = 1'b1; req_if.awaddr[1] = 32'h90;
    req_if.wvalid[1]  = 1'b1; req_if.wdata[1]  = 32'h1;
    tick();
    chk("mid_busy",        busy,           1);
    chk("mid_grant",       grant,          1);
    chk("mid_mst_awvalid", mst_if.awvalid, 1);
    #10;
    rst_n = 1'b0;
    #1;
    chk("arst_mst_awvalid", mst_if.awvalid, 0);
    chk("arst_mst_wvalid",  mst_if.wvalid,  0);
    chk("arst_busy",        busy,           0);
    chk("arst_grant",       grant,          0);
    tick();
    chk("arst_hold_busy",    busy,           0);
    chk("arst_hold_awvalid", mst_if.awvalid, 0);
    req_if.awvalid = '0; req_if.wvalid = '0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
